if_fetch: RTL and testbench

//   Instruction-fetch stage directly downstream of the PC register. Takes current_pc,

---
 rtl/if_fetch.sv | 144 ++++++++++++++
 tb/tb_if_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: credit-limited imem requests, in-order response FIFO, flush and misaligned-PC fault
module if_fetch #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic [AW-1:0] pc_in,
  output logic          pc_stall,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [DW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  output logic [AW-1:0] if_pc_plus4,
  output logic          if_fault
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [0:0] {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx, outstanding, discard;
  logic [PW-1:0] tq_wr, tq_rd, fq_wr, fq_rd, fq_rd_nx;
  logic [AW-1:0] tag_mem   [DEPTH];
  logic [AW-1:0] pc_mem    [DEPTH];
  logic [DW-1:0] instr_mem [DEPTH];
  logic [AW-1:0] head_pc;
  logic [DW-1:0] head_instr;
  logic          aligned, credit_ok, grant, resp, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stale responses still occupy credit until they return, so in-flight plus buffered never exceeds DEPTH.
  assign aligned   = (pc_in[1:0] == 2'b00);
  assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_W;
  assign imem_addr = pc_in;
  assign grant     = imem_req & imem_gnt;
  assign resp      = imem_rvalid & (outstanding != '0);
  assign push      = resp & (discard == '0) & ~flush;
  assign pop       = if_valid & if_ready & ~flush;

  // FSM state register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= RUN;
    else        state <= state_nx;
  end

  // Next state plus request/stall/fault outputs; request is held low while in reset.
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    if_fault = 1'b0;
    case (state)
      RUN: begin
        if (!flush && !aligned) state_nx = FAULT;
        imem_req = clr_n & credit_ok & ~flush & aligned;
      end
      FAULT: begin
        if_fault = 1'b1;
        if (flush) state_nx = RUN;
      end
    endcase
    pc_stall = ~flush & ~(imem_req & imem_gnt);
  end

  // Outstanding count, tag queue pointers and the count of responses to discard after a flush.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      outstanding <= '0;
      discard     <= '0;
      tq_wr       <= '0;
      tq_rd       <= '0;
    end else begin
      if (grant && !resp)      outstanding <= outstanding + 1'b1;
      else if (!grant && resp) outstanding <= outstanding - 1'b1;
      if (grant) tq_wr <= ptr_inc(tq_wr);
      if (resp)  tq_rd <= ptr_inc(tq_rd);
      if (flush)                      discard <= resp ? outstanding - 1'b1 : outstanding;
      else if (resp && discard != '0) discard <= discard - 1'b1;
    end
  end

  // Tag queue storage: PC of every granted request, consumed in order by responses.
  always_ff @(posedge clk) begin
    if (grant) tag_mem[tq_wr] <= pc_in;
  end

  // FIFO next count and next head entry, bypassing a push that lands in the new head slot.
  always_comb begin
    count_nx   = flush ? '0 : count + CW'(push) - CW'(pop);
    fq_rd_nx   = pop ? ptr_inc(fq_rd) : fq_rd;
    head_pc    = pc_mem[fq_rd_nx];
    head_instr = instr_mem[fq_rd_nx];
    if (push && fq_wr == fq_rd_nx) begin
      head_pc    = tag_mem[tq_rd];
      head_instr = imem_rdata;
    end
  end

  // FIFO pointers and registered decode-side outputs; outputs hold their last value when empty.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count       <= '0;
      fq_wr       <= '0;
      fq_rd       <= '0;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_instr    <= '0;
      if_pc_plus4 <= '0;
    end else begin
      count <= count_nx;
      fq_rd <= fq_rd_nx;
      if (flush)     fq_wr <= fq_rd_nx;
      else if (push) fq_wr <= ptr_inc(fq_wr);
      if_valid <= (count_nx != '0);
      if (count_nx != '0) begin
        if_pc       <= head_pc;
        if_instr    <= head_instr;
        if_pc_plus4 <= head_pc + AW'(4);
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[fq_wr]    <= tag_mem[tq_rd];
      instr_mem[fq_wr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard bench for if_fetch with a PC-stage and memory model
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        clr_n, flush, imem_gnt, imem_rvalid, if_ready;
  logic [31:0] pc_in, imem_rdata;
  logic        pc_stall, imem_req, if_valid, if_fault;
  logic [31:0] imem_addr, if_instr, if_pc, if_pc_plus4;

  if_fetch dut (
    .clk(clk), .clr_n(clr_n), .pc_in(pc_in), .pc_stall(pc_stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_fault(if_fault)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic stale; int rdy; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  logic [31:0] got_q[$];

  int          checks = 0, errors = 0, cyc = 0, ngrant = 0, g0 = 0, rsp_lat = 1;
  logic        nx_gnt = 0, nx_ready = 0, nx_flush = 0, hold_rsp = 1;
  logic        s_g = 0, s_st = 0, s_fl = 0;
  logic [31:0] pc, flush_tgt;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // One clock: update PC/memory models from last sample, drive inputs, sample at negedge.
  task automatic tick();
    pend_t pe;
    @(posedge clk);
    #1;
    cyc++;
    if (s_g) begin
      pend.push_back('{pc: pc, stale: 1'b0, rdy: cyc + rsp_lat - 1});
      ngrant++;
    end
    if (s_fl)       pc = flush_tgt;
    else if (!s_st) pc = pc + 32'd4;
    pc_in    = pc;
    imem_gnt = nx_gnt;
    if_ready = nx_ready;
    flush    = nx_flush;
    if (nx_flush) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_q.delete();
    end
    if (!hold_rsp && pend.size() > 0 && pend[0].rdy <= cyc) begin
      pe = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = pe.stale ? 32'hDEADBEEF : instr_of(pe.pc);
      if (!pe.stale) exp_q.push_back('{pc: pe.pc, instr: instr_of(pe.pc)});
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    @(negedge clk);
    s_g  = imem_req & imem_gnt;
    s_st = pc_stall;
    s_fl = flush;
    if (s_g) chk("imem_addr", imem_addr, pc);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_flush(input logic [31:0] tgt);
    flush_tgt = tgt;
    nx_flush  = 1'b1;
    tick();
    nx_flush  = 1'b0;
  endtask

  task automatic seq_chk(input string name, input logic [31:0] base);
    chk({name, "_count"}, 32'(got_q.size()), 32'(ngrant - g0));
    for (int i = 0; i < got_q.size(); i++) chk(name, got_q[i], base + 32'(4 * i));
    got_q.delete();
  endtask

  // Scoreboard monitor: every accepted decode-side entry must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (clr_n && !flush && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry: got pc %h instr %h, expected no entry", if_pc, if_instr);
      end else begin
        e = exp_q.pop_front();
        chk("if_pc", if_pc, e.pc);
        chk("if_instr", if_instr, e.instr);
        chk("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
      end
      got_q.push_back(if_pc);
    end
  end

  initial begin
    clr_n = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; if_ready = 1'b0;
    pc = 32'h0040_0000; pc_in = pc;
    ticks(2);
    chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_if_fault", {31'h0, if_fault}, 32'h0);
    clr_n = 1'b1;

    // T1: reset with two requests in flight
    nx_gnt = 1'b1;
    ticks(3);
    chk("t1_credit_full_req", {31'h0, imem_req}, 32'h0);
    clr_n = 1'b0;
    #1;
    chk("t1_rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("t1_rst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("t1_rst_if_fault", {31'h0, if_fault}, 32'h0);
    chk("t1_rst_if_pc", if_pc, 32'h0);
    chk("t1_rst_if_instr", if_instr, 32'h0);
    chk("t1_rst_if_pc_plus4", if_pc_plus4, 32'h0);
    foreach (pend[i]) pend[i].stale = 1'b1;
    exp_q.delete();
    s_g = 1'b0; s_fl = 1'b0;
    pc = 32'h0040_0000;
    nx_gnt = 1'b0;
    ticks(2);
    clr_n = 1'b1;
    hold_rsp = 1'b0;
    ticks(3);
    chk("t1_stale_ignored_valid", {31'h0, if_valid}, 32'h0);
    chk("t1_credit_restored_req", {31'h0, imem_req}, 32'h1);
    g0 = ngrant;
    nx_gnt = 1'b1; tick(); nx_gnt = 1'b0;
    nx_ready = 1'b1;
    ticks(4);
    seq_chk("t1_seq", 32'h0040_0000);

    // T2: streaming from 0x00400000
    do_flush(32'h0040_0000);
    g0 = ngrant;
    nx_gnt = 1'b1;
    ticks(20);
    nx_gnt = 1'b0;
    ticks(5);
    chk("t2_min_delivered", {31'h0, (ngrant - g0) >= 6}, 32'h1);
    seq_chk("t2_seq", 32'h0040_0000);

    // T3: backpressure then resume
    g0 = ngrant;
    flush_tgt = pc;
    nx_ready = 1'b0; nx_gnt = 1'b1;
    ticks(6);
    chk("t3_grants_at_stall", 32'(ngrant - g0), 32'd2);
    chk("t3_req_blocked", {31'h0, imem_req}, 32'h0);
    chk("t3_pc_stall", {31'h0, pc_stall}, 32'h1);
    nx_ready = 1'b1;
    ticks(15);
    nx_gnt = 1'b0;
    ticks(5);
    seq_chk("t3_seq", flush_tgt);

    // T4: flush with two outstanding, stale responses dropped
    hold_rsp = 1'b1; nx_gnt = 1'b1;
    ticks(3);
    chk("t4_two_outstanding_req", {31'h0, imem_req}, 32'h0);
    got_q.delete();
    nx_gnt = 1'b0;
    do_flush(32'h0040_0100);
    hold_rsp = 1'b0;
    ticks(4);
    chk("t4_stale_dropped_valid", {31'h0, if_valid}, 32'h0);
    g0 = ngrant;
    nx_gnt = 1'b1; tick(); nx_gnt = 1'b0;
    ticks(4);
    seq_chk("t4_seq", 32'h0040_0100);

    // T5: misaligned PC fault until flush
    pc = 32'h0040_0002;
    tick();
    chk("t5_req_first", {31'h0, imem_req}, 32'h0);
    chk("t5_stall_first", {31'h0, pc_stall}, 32'h1);
    nx_gnt = 1'b1;
    ticks(3);
    chk("t5_fault", {31'h0, if_fault}, 32'h1);
    chk("t5_req_in_fault", {31'h0, imem_req}, 32'h0);
    chk("t5_stall_in_fault", {31'h0, pc_stall}, 32'h1);
    nx_gnt = 1'b0;
    do_flush(32'h0040_0200);
    chk("t5_flush_stall", {31'h0, pc_stall}, 32'h0);
    tick();
    chk("t5_fault_cleared", {31'h0, if_fault}, 32'h0);
    chk("t5_req_resumed", {31'h0, imem_req}, 32'h1);
    g0 = ngrant;
    nx_gnt = 1'b1; tick(); nx_gnt = 1'b0;
    ticks(4);
    seq_chk("t5_seq", 32'h0040_0200);

    // T6a: PC+4 wraps at the top of the address space
    do_flush(32'hFFFF_FFFC);
    g0 = ngrant;
    nx_gnt = 1'b1; tick(); nx_gnt = 1'b0;
    ticks(4);
    chk("t6_hold_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("t6_hold_plus4", if_pc_plus4, 32'h0000_0000);
    chk("t6_empty_valid", {31'h0, if_valid}, 32'h0);
    seq_chk("t6_wrap_seq", 32'hFFFF_FFFC);

    // T6b: full FIFO with grant, response and pop overlapping, across the wrap
    do_flush(32'hFFFF_FFF8);
    g0 = ngrant;
    rsp_lat = 2;
    nx_ready = 1'b0; nx_gnt = 1'b1;
    ticks(6);
    chk("t6_full_valid", {31'h0, if_valid}, 32'h1);
    for (int i = 0; i < 12; i++) begin
      nx_ready = (i % 3) != 2;
      tick();
    end
    nx_gnt = 1'b0; nx_ready = 1'b1;
    ticks(8);
    seq_chk("t6_sim_seq", 32'hFFFF_FFF8);

    chk("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("end_memory_drained", 32'(pend.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
